// File: rtl/dock_pkg.sv
// ---------------------------------------------------------------------------
// dock_pkg
// Shared definitions for the dock configuration fabric:
//   dock_state_t  - transfer sequencer states
//   DOCK_ERR_DATA - read-data pattern returned for any failed access
//   DOCK_TMR_W    - width of the WAIT timeout down-counter
// ---------------------------------------------------------------------------
package dock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } dock_state_t;

    // Widest supported data bus; narrower buses take the low bits.
    localparam logic [31:0] DOCK_ERR_DATA = 32'hFFFF_FFFF;

    localparam int DOCK_TMR_W = 8;

endpackage

// File: rtl/dock_cfg_decode.sv
// ---------------------------------------------------------------------------
// dock_cfg_decode
// Combinational address decode against an ascending base-address table.
//   addr   in  CFG_ADDR_W  latched host address
//   hit    out 1           address falls inside some target window
//   sel    out NUM_TGT     one-hot selected target (all zero when unmapped)
//   offset out CFG_ADDR_W  addr minus the selected target's base
// ---------------------------------------------------------------------------
module dock_cfg_decode #(
    parameter int NUM_TGT    = 4,
    parameter int CFG_ADDR_W = 8,
    parameter logic [NUM_TGT*CFG_ADDR_W-1:0] TGT_BASE = {8'hE0, 8'hC0, 8'h40, 8'h00}
) (
    input  logic [CFG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [NUM_TGT-1:0]    sel,
    output logic [CFG_ADDR_W-1:0] offset
);

    // Bases are strictly ascending, so the highest base not above addr wins.
    always_comb begin
        sel    = '0;
        offset = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (addr >= TGT_BASE[i*CFG_ADDR_W +: CFG_ADDR_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                offset = addr - TGT_BASE[i*CFG_ADDR_W +: CFG_ADDR_W];
            end
        end
        hit = |sel;
    end

endmodule

// File: rtl/dock_cfg_fabric.sv
// ---------------------------------------------------------------------------
// dock_cfg_fabric
// Single-outstanding host-to-target configuration bridge.
// Optional error log enabled by defining DOCK_CFG_FABRIC_ERRLOG_EN.
//   clk, rst_n                 clock, async active-low reset
//   cfg_req/we/addr/wdata      host request (sampled only in IDLE)
//   cfg_rdata/ack/err/busy     host response; ack is a one-cycle pulse
//   tgt_req/we/addr/wdata      one-hot target request, held through WAIT
//   tgt_rdata/tgt_ack          per-target response, target 0 in LSBs
//   err_addr/err_cnt           (ERRLOG only) last error address, error count
//
//   state     | meaning
//   ST_IDLE   | waiting for cfg_req, request fields latched on entry to DECODE
//   ST_DECODE | address decoded, target request and timer loaded
//   ST_WAIT   | target request held until selected ack or timeout
//   ST_RESP   | cfg_ack pulse with cfg_err / cfg_rdata
// ---------------------------------------------------------------------------
module dock_cfg_fabric
    import dock_pkg::*;
#(
    parameter int NUM_TGT     = 4,
    parameter int CFG_ADDR_W  = 8,
    parameter int CFG_DATA_W  = 32,
    parameter logic [NUM_TGT*CFG_ADDR_W-1:0] TGT_BASE = {8'hE0, 8'hC0, 8'h40, 8'h00},
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_req,
    input  logic                          cfg_we,
    input  logic [CFG_ADDR_W-1:0]         cfg_addr,
    input  logic [CFG_DATA_W-1:0]         cfg_wdata,
    output logic [CFG_DATA_W-1:0]         cfg_rdata,
    output logic                          cfg_ack,
    output logic                          cfg_err,
    output logic                          cfg_busy,
    output logic [NUM_TGT-1:0]            tgt_req,
    output logic                          tgt_we,
    output logic [CFG_ADDR_W-1:0]         tgt_addr,
    output logic [CFG_DATA_W-1:0]         tgt_wdata,
    input  logic [NUM_TGT*CFG_DATA_W-1:0] tgt_rdata,
    input  logic [NUM_TGT-1:0]            tgt_ack
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
    ,
    output logic [CFG_ADDR_W-1:0]         err_addr,
    output logic [7:0]                    err_cnt
`endif
);

    dock_state_t             state, state_nxt;
    logic                    we_q;
    logic [CFG_ADDR_W-1:0]   addr_q;
    logic [CFG_DATA_W-1:0]   wdata_q;
    logic [CFG_DATA_W-1:0]   rdata_q;
    logic                    err_q;
    logic [DOCK_TMR_W-1:0]   tmr;
    logic                    dec_hit;
    logic [NUM_TGT-1:0]      dec_sel;
    logic [CFG_ADDR_W-1:0]   dec_off;
    logic                    ack_sel;
    logic                    tmr_tc;
    logic [CFG_DATA_W-1:0]   sel_rdata;
    logic                    err_evt;

    dock_cfg_decode #(
        .NUM_TGT    (NUM_TGT),
        .CFG_ADDR_W (CFG_ADDR_W),
        .TGT_BASE   (TGT_BASE)
    ) u_decode (
        .addr   (addr_q),
        .hit    (dec_hit),
        .sel    (dec_sel),
        .offset (dec_off)
    );

    // tgt_req is only non-zero in WAIT, so it doubles as the response mux select.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_req[i]) begin
                sel_rdata = sel_rdata | tgt_rdata[i*CFG_DATA_W +: CFG_DATA_W];
            end
        end
        ack_sel = |(tgt_ack & tgt_req);
        tmr_tc  = (tmr == DOCK_TMR_W'(1));
        err_evt = ((state == ST_DECODE) && !dec_hit) ||
                  ((state == ST_WAIT) && !ack_sel && tmr_tc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ack   = 1'b0;
        cfg_busy  = 1'b1;
        case (state)
            ST_IDLE: begin
                cfg_busy = 1'b0;
                if (cfg_req) state_nxt = ST_DECODE;
            end
            ST_DECODE: state_nxt = dec_hit ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                // An ack on the terminal-count cycle still counts as success.
                if (ack_sel || tmr_tc) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                cfg_ack   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        cfg_err   = cfg_ack & err_q;
        cfg_rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tmr       <= '0;
            tgt_req   <= '0;
            tgt_we    <= 1'b0;
            tgt_addr  <= '0;
            tgt_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_req) begin
                        we_q    <= cfg_we;
                        addr_q  <= cfg_addr;
                        wdata_q <= cfg_wdata;
                    end
                end
                ST_DECODE: begin
                    if (dec_hit) begin
                        tgt_req   <= dec_sel;
                        tgt_we    <= we_q;
                        tgt_addr  <= dec_off;
                        tgt_wdata <= wdata_q;
                        tmr       <= DOCK_TMR_W'(TIMEOUT_CYC);
                    end else begin
                        err_q   <= 1'b1;
                        rdata_q <= DOCK_ERR_DATA[CFG_DATA_W-1:0];
                    end
                end
                ST_WAIT: begin
                    if (ack_sel) begin
                        tgt_req <= '0;
                        tmr     <= '0;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : sel_rdata;
                    end else if (tmr_tc) begin
                        tgt_req <= '0;
                        tmr     <= '0;
                        err_q   <= 1'b1;
                        rdata_q <= DOCK_ERR_DATA[CFG_DATA_W-1:0];
                    end else begin
                        tmr <= tmr - DOCK_TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
    // Updated on entry to RESP so the log is already current during cfg_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_evt) begin
            err_addr <= addr_q;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_dock_cfg_fabric.sv
module tb_dock_cfg_fabric;

    localparam int NT = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_req = 1'b0;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [DW-1:0]     cfg_wdata = '0;
    logic [DW-1:0]     cfg_rdata;
    logic              cfg_ack, cfg_err, cfg_busy;
    logic [NT-1:0]     tgt_req;
    logic              tgt_we;
    logic [AW-1:0]     tgt_addr;
    logic [DW-1:0]     tgt_wdata;
    logic [NT*DW-1:0]  tgt_rdata = '0;
    logic [NT-1:0]     tgt_ack = '0;
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
    logic [AW-1:0]     err_addr;
    logic [7:0]        err_cnt;
    int                m_err_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference address map: target 0 starts at 0x10, so 0x00..0x0F is unmapped.
    int base_tbl[NT] = '{'h10, 'h40, 'hC0, 'hE0};

    dock_cfg_fabric #(
        .NUM_TGT     (NT),
        .CFG_ADDR_W  (AW),
        .CFG_DATA_W  (DW),
        .TGT_BASE    (32'hE0C0_4010),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .cfg_busy  (cfg_busy),
        .tgt_req   (tgt_req),
        .tgt_we    (tgt_we),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_rdata (tgt_rdata),
        .tgt_ack   (tgt_ack)
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
        ,
        .err_addr  (err_addr),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: index of the window holding addr, or -1 when unmapped.
    function automatic int model_target(input int addr);
        int t = -1;
        for (int i = 0; i < NT; i++) if (addr >= base_tbl[i]) t = i;
        return t;
    endfunction

    // One host transfer. ack_dly = WAIT cycles before the selected target acks
    // (>= TO means it never acks). noise pulses cfg_req and a foreign ack in WAIT.
    task automatic do_xfer(input string name, input logic we, input int addr,
                           input logic [DW-1:0] wdata, input int ack_dly,
                           input logic [DW-1:0] rd_val, input bit noise);
        int t, off, exp_k, wcnt;
        logic [NT-1:0] oh, other;
        logic exp_err;
        logic [DW-1:0] exp_rd;
        bit done;
        t = model_target(addr);
        off = (t >= 0) ? ((addr - base_tbl[t]) & 'hFF) : 0;
        oh = (t >= 0) ? NT'(1 << t) : '0;
        other = (t >= 0) ? NT'(1 << ((t + 1) % NT)) : '0;
        for (int i = 0; i < NT; i++) tgt_rdata[i*DW +: DW] = $urandom;
        if (t >= 0) tgt_rdata[t*DW +: DW] = rd_val;
        if (t < 0) begin
            exp_k = 2; exp_err = 1'b1;
        end else if (ack_dly < TO) begin
            exp_k = 3 + ack_dly; exp_err = 1'b0;
        end else begin
            exp_k = 2 + TO; exp_err = 1'b1;
        end
        exp_rd = exp_err ? 32'hFFFF_FFFF : (we ? 32'h0 : rd_val);
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
        if (exp_err && m_err_cnt < 255) m_err_cnt++;
`endif
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = we; cfg_addr = AW'(addr); cfg_wdata = wdata;
        wcnt = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            cfg_req = 1'b0; cfg_addr = AW'($urandom); cfg_wdata = $urandom;
            tgt_ack = '0;
            n_checks++;
            if (cfg_ack !== (k == exp_k)) begin
                n_fail++;
                $display("FAIL %s ack k=%0d: got %b expected %b", name, k, cfg_ack, k == exp_k);
            end
            if (k == exp_k) begin
                done = 1;
                n_checks++;
                if (cfg_err !== exp_err) begin
                    n_fail++;
                    $display("FAIL %s err: got %b expected %b", name, cfg_err, exp_err);
                end
                n_checks++;
                if (cfg_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", name, cfg_rdata, exp_rd);
                end
                n_checks++;
                if (tgt_req !== '0) begin
                    n_fail++;
                    $display("FAIL %s req_drop: got %b expected 0", name, tgt_req);
                end
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
                n_checks++;
                if (err_cnt !== 8'(m_err_cnt)) begin
                    n_fail++;
                    $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, m_err_cnt);
                end
                if (exp_err) begin
                    n_checks++;
                    if (err_addr !== AW'(addr)) begin
                        n_fail++;
                        $display("FAIL %s err_addr: got %h expected %h", name, err_addr, addr);
                    end
                end
`endif
            end
            if (k < exp_k) begin
                n_checks++;
                if (cfg_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy k=%0d: got %b expected 1", name, k, cfg_busy);
                end
            end
            if (k >= 2 && k < exp_k) begin
                n_checks++;
                if (tgt_req !== oh) begin
                    n_fail++;
                    $display("FAIL %s tgt_req k=%0d: got %b expected %b", name, k, tgt_req, oh);
                end
                n_checks++;
                if (tgt_addr !== AW'(off) || tgt_we !== we || tgt_wdata !== wdata) begin
                    n_fail++;
                    $display("FAIL %s tgt_fields k=%0d: got %h/%b/%h expected %h/%b/%h",
                             name, k, tgt_addr, tgt_we, tgt_wdata, off, we, wdata);
                end
            end
            if (tgt_req != '0) begin
                wcnt++;
                if (wcnt == ack_dly + 1) tgt_ack = tgt_req;
                if (noise && wcnt == 2) begin
                    cfg_req = 1'b1;
                    tgt_ack = tgt_ack | other;
                end
            end
        end
        // Response must be a single pulse, rdata must hold, nothing queued.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tgt_ack = '0;
            n_checks++;
            if (cfg_ack !== 1'b0 || cfg_busy !== 1'b0 || cfg_rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL %s after: got ack=%b busy=%b rdata=%h expected 0/0/%h",
                         name, cfg_ack, cfg_busy, cfg_rdata, exp_rd);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cfg_ack, cfg_err, cfg_busy, tgt_we} !== 4'b0 || tgt_req !== '0 ||
            cfg_rdata !== '0 || tgt_addr !== '0 || tgt_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ack=%b err=%b busy=%b req=%b rdata=%h addr=%h expected all 0",
                     cfg_ack, cfg_err, cfg_busy, tgt_req, cfg_rdata, tgt_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        do_xfer("wr41", 1'b1, 'h41, 32'h5A, 0, 32'h1234_5678, 0);
        do_xfer("rdC5", 1'b0, 'hC5, 32'h0, 3, 32'hDEAD_BEEF, 0);
        do_xfer("timeout", 1'b0, 'hE3, 32'h0, 99, 32'h1111_2222, 0);
        do_xfer("ack_wins", 1'b0, 'hE7, 32'h0, TO - 1, 32'hCAFE_F00D, 0);
        do_xfer("unmapped", 1'b0, 'h05, 32'h0, 0, 32'h0, 0);
        do_xfer("base_edge", 1'b0, 'h3F, 32'h0, 1, 32'hA5A5_0001, 0);
        do_xfer("top_edge", 1'b1, 'hFF, 32'h77, 2, 32'h0, 0);
    endtask

    task automatic test_ignored_inputs;
        do_xfer("noise", 1'b0, 'h48, 32'h0, 5, 32'h0BAD_F00D, 1);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'hC8;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            cfg_req = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tgt_req !== '0 || cfg_busy !== 1'b0 || cfg_ack !== 1'b0 || tgt_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b busy=%b ack=%b addr=%h expected 0",
                     tgt_req, cfg_busy, cfg_ack, tgt_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cfg_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_noack: got %b expected 0", cfg_ack);
            end
        end
        rst_n = 1'b1;
`ifdef DOCK_CFG_FABRIC_ERRLOG_EN
        m_err_cnt = 0;
`endif
        do_xfer("post_reset", 1'b0, 'hC2, 32'h0, 1, 32'h600D_0001, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            int a, d;
            logic w;
            a = $urandom_range(0, 255);
            w = 1'($urandom);
            d = $urandom_range(0, TO + 3);
            do_xfer($sformatf("rnd%0d", n), w, a, $urandom, d, $urandom,
                    (d >= 3) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_inputs();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
